// File: rtl/secded_router_pipe_pkg.sv
// Shared codeword geometry and the Hamming(7,4)+overall-parity encoder used by the router pipe.
package secded_router_pipe_pkg;

    localparam int unsigned CW_W   = 8;
    localparam int unsigned DATA_W = 4;

    // Bit positions inside cw[7:0]; position 0 carries the overall parity.
    localparam int unsigned PosP0 = 0;
    localparam int unsigned PosP1 = 1;
    localparam int unsigned PosP2 = 2;
    localparam int unsigned PosD0 = 3;
    localparam int unsigned PosP4 = 4;
    localparam int unsigned PosD1 = 5;
    localparam int unsigned PosD2 = 6;
    localparam int unsigned PosD3 = 7;

    function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw        = '0;
        cw[PosD0] = d[0];
        cw[PosD1] = d[1];
        cw[PosD2] = d[2];
        cw[PosD3] = d[3];
        cw[PosP1] = d[0] ^ d[1] ^ d[3];
        cw[PosP2] = d[0] ^ d[2] ^ d[3];
        cw[PosP4] = d[1] ^ d[2] ^ d[3];
        cw[PosP0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

endpackage

// File: rtl/secded_router_pipe_dec8.sv
// Combinational SEC-DED / SEC-only decoder for one 8-bit codeword.
module secded_dec8
    import secded_router_pipe_pkg::*;
#(
    parameter bit SECDED = 1'b1
) (
    input  logic [CW_W-1:0]   cw_i,
    output logic [DATA_W-1:0] data_o,
    output logic              corr_o,
    output logic              uncorr_o
);

    logic [2:0]      syn;
    logic            par;
    logic [CW_W-1:0] fixed;

    always_comb begin
        syn[0]   = cw_i[1] ^ cw_i[3] ^ cw_i[5] ^ cw_i[7];
        syn[1]   = cw_i[2] ^ cw_i[3] ^ cw_i[6] ^ cw_i[7];
        syn[2]   = cw_i[4] ^ cw_i[5] ^ cw_i[6] ^ cw_i[7];
        par      = ^cw_i;
        fixed    = cw_i;
        corr_o   = 1'b0;
        uncorr_o = 1'b0;
        if (SECDED) begin
            // Odd overall parity means one flipped bit; syndrome 0 points at cw0 itself.
            if (par) begin
                corr_o = 1'b1;
                if (syn != 3'd0) begin
                    fixed[syn] = ~fixed[syn];
                end
            end else if (syn != 3'd0) begin
                uncorr_o = 1'b1;
            end
        end else if (syn != 3'd0) begin
            fixed[syn] = ~fixed[syn];
            corr_o     = 1'b1;
        end
        data_o = {fixed[PosD3], fixed[PosD2], fixed[PosD1], fixed[PosD0]};
    end

endmodule

// File: rtl/secded_router_pipe.sv
// Three-stage encode -> route/fault-inject -> decode pipe with saturating per-channel counters.
module secded_router_pipe
    import secded_router_pipe_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned SECDED = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [CH_W-1:0]          in_dest,
    input  logic [NUM_CH*CW_W-1:0]   inj_mask,
    input  logic                     cnt_clr,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_corr,
    output logic [NUM_CH-1:0]        out_uncorr,
    output logic [NUM_CH*CNT_W-1:0]  corr_cnt,
    output logic [NUM_CH*CNT_W-1:0]  uncorr_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [NUM_CH-1:0]             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [NUM_CH-1:0][CW_W-1:0]   s1_cw_q, s1_cw_d, s2_cw_q, s2_cw_d;
    logic [NUM_CH-1:0]             out_valid_q, out_valid_d;
    logic [NUM_CH-1:0][DATA_W-1:0] out_data_q, out_data_d, dec_data;
    logic [NUM_CH-1:0]             out_corr_q, out_corr_d, out_uncorr_q, out_uncorr_d;
    logic [NUM_CH-1:0]             dec_corr, dec_uncorr;
    logic [NUM_CH-1:0][CNT_W-1:0]  corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
    logic [CNT_W-1:0]              drop_cnt_q, drop_cnt_d;
    logic                          dest_ok;
    logic [CW_W-1:0]               enc_cw;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dec
        secded_dec8 #(
            .SECDED (SECDED != 0)
        ) u_dec (
            .cw_i     (s2_cw_q[k]),
            .data_o   (dec_data[k]),
            .corr_o   (dec_corr[k]),
            .uncorr_o (dec_uncorr[k])
        );
    end

    always_comb begin
        dest_ok      = 32'(in_dest) < NUM_CH;
        enc_cw       = secded_encode(in_data);
        s1_valid_d   = '0;
        s1_cw_d      = s1_cw_q;
        s2_valid_d   = s1_valid_q;
        s2_cw_d      = s2_cw_q;
        out_valid_d  = s2_valid_q;
        out_data_d   = out_data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (in_valid && dest_ok && (in_dest == CH_W'(k))) begin
                s1_valid_d[k] = 1'b1;
                s1_cw_d[k]    = enc_cw;
            end
            if (s1_valid_q[k]) begin
                s2_cw_d[k] = s1_cw_q[k] ^ inj_mask[k*CW_W +: CW_W];
            end
            if (s2_valid_q[k]) begin
                out_data_d[k]   = dec_data[k];
                out_corr_d[k]   = dec_corr[k];
                out_uncorr_d[k] = dec_uncorr[k];
            end
            // Clear overrides any same-cycle increment.
            if (cnt_clr) begin
                corr_cnt_d[k]   = '0;
                uncorr_cnt_d[k] = '0;
            end else begin
                if (out_valid_q[k] && out_corr_q[k] && corr_cnt_q[k] != CntMax) begin
                    corr_cnt_d[k] = corr_cnt_q[k] + CNT_W'(1);
                end
                if (out_valid_q[k] && out_uncorr_q[k] && uncorr_cnt_q[k] != CntMax) begin
                    uncorr_cnt_d[k] = uncorr_cnt_q[k] + CNT_W'(1);
                end
            end
        end
        if (cnt_clr) begin
            drop_cnt_d = '0;
        end else if (in_valid && !dest_ok && drop_cnt_q != CntMax) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= '0;
            s1_cw_q      <= '0;
            s2_valid_q   <= '0;
            s2_cw_q      <= '0;
            out_valid_q  <= '0;
            out_data_q   <= '0;
            out_corr_q   <= '0;
            out_uncorr_q <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            s2_valid_q   <= s2_valid_d;
            s2_cw_q      <= s2_cw_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_corr   = out_corr_q;
    assign out_uncorr = out_uncorr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_secded_router_pipe.sv
// Directed bench: a 3-channel SEC-DED instance with 2-bit counters and a 4-channel SEC-only one.
module tb_secded_router_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_data;
    logic [1:0]  in_dest;
    logic        cnt_clr;

    logic [23:0] mask_a;
    logic [2:0]  out_valid_a, out_corr_a, out_uncorr_a;
    logic [11:0] out_data_a;
    logic [5:0]  corr_cnt_a, uncorr_cnt_a;
    logic [1:0]  drop_cnt_a;

    logic [31:0] mask_b;
    logic [3:0]  out_valid_b, out_corr_b, out_uncorr_b;
    logic [15:0] out_data_b;
    logic [31:0] corr_cnt_b, uncorr_cnt_b;
    logic [7:0]  drop_cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    secded_router_pipe #(
        .NUM_CH (3),
        .CH_W   (2),
        .SECDED (1),
        .CNT_W  (2)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .inj_mask   (mask_a),
        .cnt_clr    (cnt_clr),
        .out_valid  (out_valid_a),
        .out_data   (out_data_a),
        .out_corr   (out_corr_a),
        .out_uncorr (out_uncorr_a),
        .corr_cnt   (corr_cnt_a),
        .uncorr_cnt (uncorr_cnt_a),
        .drop_cnt   (drop_cnt_a)
    );

    secded_router_pipe #(
        .NUM_CH (4),
        .CH_W   (2),
        .SECDED (0),
        .CNT_W  (8)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .inj_mask   (mask_b),
        .cnt_clr    (cnt_clr),
        .out_valid  (out_valid_b),
        .out_data   (out_data_b),
        .out_corr   (out_corr_b),
        .out_uncorr (out_uncorr_b),
        .corr_cnt   (corr_cnt_b),
        .uncorr_cnt (uncorr_cnt_b),
        .drop_cnt   (drop_cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] dest);
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dest;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_dest  = '0;
        cnt_clr  = 1'b0;
        mask_a   = '0;
        mask_b   = '0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid_a), 32'h0);
        chk("rst_corr_cnt", 32'(corr_cnt_a), 32'h0);
        chk("rst_uncorr_cnt", 32'(uncorr_cnt_a), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt_a), 32'h0);
        rst_n = 1'b1;
        tick();

        // Clean word 1001 -> ch2
        send(4'b1001, 2'd2);
        chk("s1_codeword", 32'(dut_a.s1_cw_q[2]), 32'h99);
        tick();
        chk("clean_not_early", 32'(out_valid_a), 32'h0);
        tick();
        chk("clean_valid", 32'(out_valid_a), 32'b100);
        chk("clean_data", 32'(out_data_a[11:8]), 32'b1001);
        chk("clean_corr", 32'(out_corr_a[2]), 32'h0);
        chk("clean_uncorr", 32'(out_uncorr_a[2]), 32'h0);
        chk("clean_valid_b", 32'(out_valid_b), 32'b0100);
        tick();
        chk("valid_pulse", 32'(out_valid_a), 32'h0);
        chk("data_hold", 32'(out_data_a[11:8]), 32'b1001);

        // Single error on cw5
        mask_a[23:16] = 8'h20;
        send(4'b1001, 2'd2);
        tick();
        tick();
        chk("sec_data", 32'(out_data_a[11:8]), 32'b1001);
        chk("sec_corr", 32'(out_corr_a[2]), 32'h1);
        chk("sec_uncorr", 32'(out_uncorr_a[2]), 32'h0);
        tick();
        chk("sec_corr_cnt", 32'(corr_cnt_a[5:4]), 32'h1);
        mask_a = '0;

        // Double error on cw3,cw4 -> ch0
        mask_a[7:0] = 8'h18;
        mask_b[7:0] = 8'h18;
        send(4'b1001, 2'd0);
        tick();
        tick();
        chk("ded_uncorr", 32'(out_uncorr_a[0]), 32'h1);
        chk("ded_corr", 32'(out_corr_a[0]), 32'h0);
        chk("ded_data_raw", 32'(out_data_a[3:0]), 32'b1000);
        chk("seconly_corr", 32'(out_corr_b[0]), 32'h1);
        chk("seconly_uncorr", 32'(out_uncorr_b[0]), 32'h0);
        chk("seconly_data", 32'(out_data_b[3:0]), 32'b0000);
        tick();
        chk("ded_uncorr_cnt", 32'(uncorr_cnt_a[1:0]), 32'h1);
        chk("seconly_corr_cnt", 32'(corr_cnt_b[7:0]), 32'h1);
        chk("seconly_uncorr_cnt", 32'(uncorr_cnt_b[7:0]), 32'h0);
        mask_a = '0;
        mask_b = '0;

        // Overall-parity bit error, payload 0110 (cw 0x66) -> ch1
        mask_a[15:8] = 8'h01;
        send(4'b0110, 2'd1);
        tick();
        tick();
        chk("par_corr", 32'(out_corr_a[1]), 32'h1);
        chk("par_data", 32'(out_data_a[7:4]), 32'b0110);
        mask_a = '0;
        tick();

        // Invalid destination on the 3-channel instance
        send(4'b1001, 2'd3);
        chk("drop_cnt", 32'(drop_cnt_a), 32'h1);
        chk("drop_cnt_b", 32'(drop_cnt_b), 32'h0);
        tick();
        chk("drop_no_valid1", 32'(out_valid_a), 32'h0);
        tick();
        chk("drop_no_valid2", 32'(out_valid_a), 32'h0);
        chk("b_ch3_valid", 32'(out_valid_b), 32'b1000);

        // Back-to-back to channels 0,1,2
        in_valid = 1'b1;
        in_dest = 2'd0; in_data = 4'b0001; tick();
        in_dest = 2'd1; in_data = 4'b0010; tick();
        in_dest = 2'd2; in_data = 4'b0100; tick();
        in_valid = 1'b0;
        chk("b2b_valid0", 32'(out_valid_a), 32'b001);
        chk("b2b_data0", 32'(out_data_a[3:0]), 32'b0001);
        tick();
        chk("b2b_valid1", 32'(out_valid_a), 32'b010);
        chk("b2b_data1", 32'(out_data_a[7:4]), 32'b0010);
        tick();
        chk("b2b_valid2", 32'(out_valid_a), 32'b100);
        chk("b2b_data2", 32'(out_data_a[11:8]), 32'b0100);
        tick();
        chk("b2b_idle", 32'(out_valid_a), 32'h0);

        // Clear, then saturate a 2-bit counter with five corrected words
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_corr_cnt", 32'(corr_cnt_a), 32'h0);
        chk("clr_uncorr_cnt", 32'(uncorr_cnt_a), 32'h0);
        chk("clr_drop_cnt", 32'(drop_cnt_a), 32'h0);
        mask_a[23:16] = 8'h20;
        in_valid = 1'b1;
        in_dest  = 2'd2;
        in_data  = 4'b1001;
        repeat (5) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("sat_corr_cnt", 32'(corr_cnt_a[5:4]), 32'h3);
        chk("sat_other_ch", 32'(corr_cnt_a[3:0]), 32'h0);

        // Clear coincident with an increment
        send(4'b1001, 2'd2);
        tick();
        tick();
        chk("clr_race_valid", 32'(out_valid_a[2]), 32'h1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_wins", 32'(corr_cnt_a[5:4]), 32'h0);
        tick();
        chk("clr_stays", 32'(corr_cnt_a[5:4]), 32'h0);
        mask_a = '0;

        // Reset one cycle after an accept discards the word
        send(4'b1001, 2'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid1", 32'(out_valid_a), 32'h0);
        tick();
        chk("midrst_valid2", 32'(out_valid_a), 32'h0);
        chk("midrst_valid2_b", 32'(out_valid_b), 32'h0);
        tick();
        chk("midrst_valid3", 32'(out_valid_a), 32'h0);
        chk("midrst_data", 32'(out_data_a), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/secded_router_pipe.md
Name: secded_router_pipe

Overview:
Parametrised successor to the 4-channel Hamming(7,4) secure-router chain. It is a single pipelined block that does the following in order: encodes a 4-bit payload into an 8-bit SEC-DED codeword, routes it to one of NUM_CH channels, applies a per-channel fault-injection mask, then decodes and corrects it. It adds things the old chain lacked: a valid handshake, double-error detection, a SEC-only mode, invalid-destination drop, and saturating per-channel error counters. It sits between the router input stage and the display/consumer logic.

Parameters:
NUM_CH, 4, number of output channels (1..16)
CH_W, 2, destination index width; must be at least clog2(NUM_CH), minimum 1
SECDED, 1, 1 = SEC-DED decode using overall parity; 0 = SEC only, bit 0 ignored
CNT_W, 8, width of each error/drop counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  input word valid this cycle
in_data  in  4  payload d[3:0]
in_dest  in  CH_W  destination channel
inj_mask  in  NUM_CH*8  per-channel XOR fault mask; channel k uses bits [8k+7:8k]
cnt_clr  in  1  synchronous clear of all counters
out_valid  out  NUM_CH  per-channel output valid
out_data  out  NUM_CH*4  per-channel corrected payload
out_corr  out  NUM_CH  a single error was corrected (qualified by out_valid)
out_uncorr  out  NUM_CH  an uncorrectable double error was detected (qualified by out_valid)
corr_cnt  out  NUM_CH*CNT_W  per-channel corrected-error count
uncorr_cnt  out  NUM_CH*CNT_W  per-channel uncorrectable-error count
drop_cnt  out  CNT_W  count of words dropped for an invalid destination

Behaviour:
- Reset: when rst_n=0 at a clk edge, all pipeline valids, out_*, and all counters are set to 0. Reset takes priority over everything, and in-flight words are discarded.
- Codeword layout, cw[7:0]:
  - cw1=p1, cw2=p2, cw3=d0, cw4=p4, cw5=d1, cw6=d2, cw7=d3.
  - p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
  - cw0 = XOR of cw[7:1].
- Stage 1 (registered): when in_valid=1 and in_dest<NUM_CH, encode the payload and latch the codeword into the stage-1 slot for channel in_dest. When in_dest>=NUM_CH, the word is dropped and drop_cnt increments.
- Stage 2 (registered): for each channel with a valid word, cw ^= inj_mask[channel]. inj_mask is sampled in the same cycle the word moves from stage 1 to stage 2.
- Stage 3 (registered): decode.
  - Syndrome s = {s4,s2,s1}, where s1 = XOR of positions 1,3,5,7; s2 = XOR of positions 2,3,6,7; s4 = XOR of positions 4,5,6,7.
  - P = XOR of cw[7:0].
  - SECDED=1:
    - s=0, P=0: clean.
    - P=1: single error. If s≠0, flip bit s; if s=0, the error is in cw0 and the data is already good. Set corr.
    - s≠0, P=0: double error. Output the uncorrected data bits and set uncorr.
  - SECDED=0: any s≠0 flips bit s and sets corr. uncorr is never asserted.
- Latency: exactly 3 clk edges from in_valid to out_valid. Throughput is one word per cycle. There is no backpressure.
- out_data, out_corr and out_uncorr hold their last values while out_valid=0. Only out_valid pulses.
- Counters:
  - corr_cnt[k] increments when out_valid[k] & out_corr[k].
  - uncorr_cnt[k] increments when out_valid[k] & out_uncorr[k].
  - All counters saturate at 2^CNT_W-1 and do not wrap.
  - If cnt_clr and an increment occur in the same cycle, clear wins and the result is 0.
- Per-channel independence: every channel has its own pipeline slot. Only one input word enters per cycle, so at most one out_valid bit is set per cycle.
- Reset asserted mid-flight: no output valid is produced for any word that was accepted before the reset.

Decomposition:
- Shared include file `secded_defs.vh` holds:
  - CW_W=8 and DATA_W=4 constants.
  - Bit-position localparams for p1/p2/p4/d0..d3.
- Sub-module `secded_dec8`: combinational decoder (cw, secded mode → data, corr, uncorr), instantiated NUM_CH times in stage 3.
- The encoder is small and stays inline.

Test Plan:
- Clean path: in_data=4'b1001, dest=2, mask=0. Stage-1 codeword is 8'h99. Three cycles later out_valid=4'b0100, channel-2 data=1001, corr=0, uncorr=0.
- Single error: same input, mask ch2 = 8'h20 (cw5). Output data=1001, corr=1, corr_cnt[2]=1.
- Double error: mask ch0 = 8'h18, dest=0. uncorr=1, uncorr_cnt[0]=1. Repeat with SECDED=0: corr=1, uncorr never asserted.
- Parity-bit error: mask = 8'h01. corr=1 and data unchanged.
- Invalid destination: NUM_CH=3, dest=3. No out_valid is raised and drop_cnt=1. Back-to-back words to channels 0,1,2 give one out_valid per cycle, in order, at latency 3.
- Counters and reset:
  - CNT_W=2: send 5 corrected words. corr_cnt saturates at 3.
  - Pulse cnt_clr together with an increment: counter reads 0.
  - Assert rst_n=0 one cycle after an accept: no out_valid follows.
